// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: owns the PC, selects sequential/branch/jump next PC,
// honours hazard stalls, drives the IMEM req/ack handshake and squashes
// wrong-path fetches.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_3000,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             ReSet_n,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchAddr,
    input  logic             JumpTaken,
    input  logic [31:0]      JumpAddr,
    input  logic             ImemAck,
    output logic [31:0]      PC,
    output logic             ImemReq,
    output logic             IfValid,
    output logic             IfIdFlush,
    output logic [CNT_W-1:0] RedirCnt
);

    localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        FETCH      = 2'd1,
        REDIR_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [BOOT_W-1:0] bootCnt;
    logic [31:0]       pend;

    logic              redirect;
    logic [31:0]       targetRaw;
    logic [31:0]       target;
    logic              cntSat;

    // Redirect decode: jump wins over branch, target forced word-aligned.
    assign redirect  = BranchTaken | JumpTaken;
    assign targetRaw = JumpTaken ? JumpAddr : BranchAddr;
    assign target    = targetRaw & 32'hFFFF_FFFC;
    assign cntSat    = &RedirCnt;

    // Handshake/IF-ID controls follow the state directly so reset clears them at once.
    assign ImemReq   = (state != BOOT);
    assign IfValid   = (state == FETCH) & ImemAck & ~redirect & ~Stall;
    assign IfIdFlush = (state == FETCH) & redirect;

    // Sequencer: boot delay, PC update and pending-redirect tracking.
    always_ff @(posedge Clk or negedge ReSet_n) begin
        if (!ReSet_n) begin
            state   <= BOOT;
            bootCnt <= '0;
            pend    <= '0;
            PC      <= RESET_VEC;
        end else begin
            case (state)
                BOOT: begin
                    if (bootCnt == BOOT_LAST) begin
                        state <= FETCH;
                    end else begin
                        bootCnt <= bootCnt + BOOT_W'(1);
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        if (ImemAck) begin
                            PC <= target;
                        end else begin
                            pend  <= target;
                            state <= REDIR_WAIT;
                        end
                    end else if (!Stall && ImemAck) begin
                        PC <= PC + 32'd4;
                    end
                end
                REDIR_WAIT: begin
                    if (ImemAck) begin
                        PC    <= redirect ? target : pend;
                        state <= FETCH;
                    end else if (redirect) begin
                        pend <= target;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    // Saturating count of accepted redirects (ignored during boot).
    always_ff @(posedge Clk or negedge ReSet_n) begin
        if (!ReSet_n) begin
            RedirCnt <= '0;
        end else if (redirect && (state != BOOT) && !cntSat) begin
            RedirCnt <= RedirCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, checked
// against a transaction-level model of the fetch controller.
module tb_pc_sequencer;

    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] RVEC  = 32'h0000_3000;

    logic             Clk = 1'b0;
    logic             ReSet_n = 1'b1;
    logic             Stall = 1'b0;
    logic             BranchTaken = 1'b0;
    logic [31:0]      BranchAddr = '0;
    logic             JumpTaken = 1'b0;
    logic [31:0]      JumpAddr = '0;
    logic             ImemAck = 1'b0;
    logic [31:0]      PC;
    logic             ImemReq;
    logic             IfValid;
    logic             IfIdFlush;
    logic [CNT_W-1:0] RedirCnt;

    pc_sequencer #(
        .RESET_VEC  (RVEC),
        .BOOT_CYCLES(2),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk        (Clk),
        .ReSet_n    (ReSet_n),
        .Stall      (Stall),
        .BranchTaken(BranchTaken),
        .BranchAddr (BranchAddr),
        .JumpTaken  (JumpTaken),
        .JumpAddr   (JumpAddr),
        .ImemAck    (ImemAck),
        .PC         (PC),
        .ImemReq    (ImemReq),
        .IfValid    (IfValid),
        .IfIdFlush  (IfIdFlush),
        .RedirCnt   (RedirCnt)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: boot cycles left, whether a redirect is waiting on an
    // in-flight fetch, its target, the PC and total redirects seen.
    int          m_boot_left;
    bit          m_waiting;
    logic [31:0] m_pend;
    logic [31:0] m_pc;
    int          m_redirects;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
        return (m_redirects >= 15) ? 32'd15 : 32'(m_redirects);
    endfunction

    task automatic model_reset();
        m_boot_left = 2;
        m_waiting   = 1'b0;
        m_pend      = '0;
        m_pc        = RVEC;
        m_redirects = 0;
    endtask

    // Called at a negedge: drive inputs, check outputs, clock once, advance model.
    task automatic step(input bit st, input bit bt, input logic [31:0] ba,
                        input bit jt, input logic [31:0] ja, input bit ack);
        bit          redir;
        logic [31:0] tgt;
        bit          fetching;
        Stall = st; BranchTaken = bt; BranchAddr = ba;
        JumpTaken = jt; JumpAddr = ja; ImemAck = ack;
        redir    = bt | jt;
        tgt      = {(jt ? ja[31:2] : ba[31:2]), 2'b00};
        fetching = (m_boot_left == 0) && !m_waiting;
        #1;
        check("pc",      PC,                m_pc);
        check("imemreq", 32'(ImemReq),      32'(m_boot_left == 0));
        check("ifvalid", 32'(IfValid),      32'(fetching && ack && !redir && !st));
        check("flush",   32'(IfIdFlush),    32'(fetching && redir));
        check("redircnt", 32'(RedirCnt),    exp_cnt());
        @(posedge Clk);
        if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (!m_waiting) begin
            if (redir) begin
                m_redirects++;
                if (ack) m_pc = tgt;
                else begin m_waiting = 1'b1; m_pend = tgt; end
            end else if (!st && ack) begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (redir) m_redirects++;
            if (ack) begin
                m_pc = redir ? tgt : m_pend;
                m_waiting = 1'b0;
            end else if (redir) begin
                m_pend = tgt;
            end
        end
        @(negedge Clk);
    endtask

    // Called at a negedge: pulse reset mid-cycle, check async clear, release at next negedge.
    task automatic pulse_reset();
        #2 ReSet_n = 1'b0;
        #1;
        check("rst_pc",    PC,                RVEC);
        check("rst_req",   32'(ImemReq),      32'd0);
        check("rst_valid", 32'(IfValid),      32'd0);
        check("rst_flush", 32'(IfIdFlush),    32'd0);
        check("rst_cnt",   32'(RedirCnt),     32'd0);
        model_reset();
        Stall = 1'b0; BranchTaken = 1'b0; JumpTaken = 1'b0; ImemAck = 1'b0;
        @(negedge Clk);
        ReSet_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 ReSet_n = 1'b0;
        #1;
        check("init_pc",  PC,           RVEC);
        check("init_req", 32'(ImemReq), 32'd0);
        @(negedge Clk);
        ReSet_n = 1'b1;

        // Boot then sequential fetch: 3000, 3004, 3008
        for (int i = 0; i < 5; i++) step(0, 0, '0, 0, '0, 1);
        check("seq_pc_300c", PC, 32'h0000_300C);
        // Stall three clocks at 300C with ack asserted
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0, '0, 1);
        check("stall_hold", PC, 32'h0000_300C);
        step(0, 0, '0, 0, '0, 1);
        check("resume_3010", PC, 32'h0000_3010);
        // Branch to unaligned 3101 with ack
        step(0, 1, 32'h0000_3101, 0, '0, 1);
        check("branch_3100", PC, 32'h0000_3100);
        check("branch_cnt", 32'(RedirCnt), 32'd1);
        // Jump+branch with IMEM slow: jump wins after the wait
        step(0, 1, 32'h0000_5000, 1, 32'h0000_4000, 0);
        step(0, 0, '0, 0, '0, 0);
        step(1, 0, '0, 0, '0, 1);
        check("jump_4000", PC, 32'h0000_4000);
        // Reset in the middle of REDIR_WAIT
        step(0, 0, '0, 1, 32'h0000_7000, 0);
        pulse_reset();

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) pulse_reset();
            step(($urandom_range(4) == 0), ($urandom_range(6) == 0), $urandom(),
                 ($urandom_range(9) == 0), $urandom(), ($urandom_range(9) < 6));
        end

        // Counter saturation and PC wrap at the top of the address space
        pulse_reset();
        step(0, 0, '0, 0, '0, 0);
        step(0, 0, '0, 0, '0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 32'hFFFF_FFFC, 0, '0, 1);
        check("cnt_sat", 32'(RedirCnt), 32'h0000_000F);
        step(0, 0, '0, 0, '0, 1);
        check("pc_wrap", PC, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
